// File: rtl/delay_pkg.sv
// Shared types and defaults for the delay_bank channel array.
// Channel FSM states and the per-channel load payload live here.
package delay_pkg;

  typedef enum logic {
    RUN,
    DONE
  } chan_state_t;

  localparam int CBITS_DEF     = 10;
  localparam int N_DEFAULT_DEF = 750;

  typedef struct packed {
    logic [CBITS_DEF-1:0] period;
    logic                 oneshot;
  } chan_cfg_t;

endpackage

// File: rtl/delay_chan.sv
// One delay channel: counter, RUN/DONE FSM and registered sig/err/flg.
// A load always wins over counting in the same cycle.
module delay_chan
  import delay_pkg::*;
#(
  parameter int  CBITS     = CBITS_DEF,
  parameter int  N_DEFAULT = N_DEFAULT_DEF,
  parameter type cfg_t     = chan_cfg_t
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  cfg_t cfg,
  output logic sig,
  output logic err,
  output logic flg
);

  chan_state_t      state, state_n;
  logic [CBITS-1:0] cnt, cnt_n;
  logic [CBITS-1:0] period, period_n;
  logic             oneshot, oneshot_n;
  logic             sig_n;

  // Next-state: load first, else count while armed and enabled.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    period_n  = period;
    oneshot_n = oneshot;
    sig_n     = 1'b0;
    if (load) begin
      period_n  = cfg.period;
      oneshot_n = cfg.oneshot;
      cnt_n     = '0;
      state_n   = RUN;
    end else if (state == DONE) begin
      cnt_n = '0;
    end else if (en) begin
      if (cnt == period) begin
        cnt_n = '0;
        sig_n = 1'b1;
        if (oneshot) state_n = DONE;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
  end

  // State and output registers; flags derive from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      period  <= CBITS'(N_DEFAULT);
      oneshot <= 1'b0;
      sig     <= 1'b0;
      err     <= 1'b0;
      flg     <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      period  <= period_n;
      oneshot <= oneshot_n;
      sig     <= sig_n;
      err     <= (cnt_n > period_n);
      flg     <= (state_n == RUN) && (cnt_n <= period_n);
    end
  end

endmodule

// File: rtl/delay_bank.sv
// Bank of NCH programmable delay channels behind one config port.
// The port accepts at most one write every two cycles.
module delay_bank
  import delay_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CBITS     = CBITS_DEF,
  parameter int N_DEFAULT = N_DEFAULT_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NCH-1:0]                     en,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [((NCH>1)?$clog2(NCH):1)-1:0] cfg_ch,
  input  logic [CBITS-1:0]                   cfg_period,
  input  logic                               cfg_oneshot,
  output logic                               cfg_err,
  output logic [NCH-1:0]                     sig,
  output logic [NCH-1:0]                     err,
  output logic [NCH-1:0]                     flg
);

  typedef struct packed {
    logic [CBITS-1:0] period;
    logic             oneshot;
  } cfg_t;

  logic accept;
  logic bad_ch;
  cfg_t cfg;

  assign accept = cfg_valid && cfg_ready;
  assign bad_ch = int'(cfg_ch) >= NCH;
  assign cfg    = '{period: cfg_period, oneshot: cfg_oneshot};

  // Handshake: ready drops for the cycle after each accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= !accept;
      cfg_err   <= accept && bad_ch;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    delay_chan #(
      .CBITS    (CBITS),
      .N_DEFAULT(N_DEFAULT),
      .cfg_t    (cfg_t)
    ) u_chan (
      .clk (clk),
      .rst (rst),
      .en  (en[i]),
      .load(accept && (int'(cfg_ch) == i)),
      .cfg (cfg),
      .sig (sig[i]),
      .err (err[i]),
      .flg (flg[i])
    );
  end

endmodule

// File: tb/tb_delay_bank.sv
// Directed bench for delay_bank with NCH=3 so cfg_ch=3 is out of range.
// Each task drives one scenario and checks hand-computed values.
module tb_delay_bank;

  localparam int NCH = 3;
  localparam int CB  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    en = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_ch = '0;
  logic [CB-1:0] cfg_period = '0;
  logic          cfg_oneshot = 1'b0;
  logic          cfg_err;
  logic [2:0]    sig;
  logic [2:0]    err;
  logic [2:0]    flg;

  int passed = 0;
  int total  = 0;

  delay_bank #(
    .NCH      (NCH),
    .CBITS    (CB),
    .N_DEFAULT(750)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_oneshot(cfg_oneshot),
    .cfg_err    (cfg_err),
    .sig        (sig),
    .err        (err),
    .flg        (flg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] ch, input int p, input logic os);
    int w = 0;
    while (!cfg_ready && w < 4) begin
      tick();
      w++;
    end
    total++;
    if (!cfg_ready)
      $display("FAIL write_ready: cfg_ready=%b required 1", cfg_ready);
    else passed++;
    cfg_valid   = 1'b1;
    cfg_ch      = ch;
    cfg_period  = CB'(p);
    cfg_oneshot = os;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = '1;
    tick();
    tick();
    total++;
    if ({sig, err, flg, cfg_ready, cfg_err} !== {3'b000, 3'b000, 3'b111, 1'b0, 1'b0})
      $display("FAIL reset_vals: sig=%b err=%b flg=%b rdy=%b cerr=%b required 000 000 111 0 0",
               sig, err, flg, cfg_ready, cfg_err);
    else passed++;
  endtask

  task automatic test_default_period();
    int first = 0, second = 0;
    logic [2:0] fsig = '0;
    logic [2:0] err_or = '0;
    logic flg_bad = 1'b0;
    rst = 1'b0;
    en  = '1;
    tick();
    total++;
    if (cfg_ready !== 1'b1)
      $display("FAIL ready_after_reset: cfg_ready=%b required 1", cfg_ready);
    else passed++;
    if (sig != 0) first = 1;
    for (int k = 2; k <= 1502; k++) begin
      tick();
      if (sig != 0) begin
        if (first == 0) begin
          first = k;
          fsig  = sig;
        end else if (second == 0) second = k;
      end
      err_or |= err;
      if (flg !== 3'b111) flg_bad = 1'b1;
    end
    total++;
    if (first !== 751)
      $display("FAIL default_first: edge=%0d required 751", first);
    else passed++;
    total++;
    if (fsig !== 3'b111)
      $display("FAIL default_all_ch: sig=%b required 111", fsig);
    else passed++;
    total++;
    if (second !== 1502)
      $display("FAIL default_second: edge=%0d required 1502", second);
    else passed++;
    total++;
    if (err_or !== 3'b000 || flg_bad !== 1'b0)
      $display("FAIL default_err_flg: err_or=%b flg_bad=%b required 000 0", err_or, flg_bad);
    else passed++;
  endtask

  task automatic test_periodic_write();
    logic [11:0] mask = '0;
    logic [1:0] oth = '0;
    write(2'd2, 3, 1'b0);
    total++;
    if (cfg_ready !== 1'b0)
      $display("FAIL ready_drop: cfg_ready=%b required 0", cfg_ready);
    else passed++;
    for (int k = 1; k <= 12; k++) begin
      tick();
      mask[k-1] = sig[2];
      oth |= sig[1:0];
    end
    total++;
    if (mask !== 12'h888)
      $display("FAIL ch2_p3: mask=%h required 888", mask);
    else passed++;
    total++;
    if (oth !== 2'b00)
      $display("FAIL others_undisturbed: sig_or=%b required 00", oth);
    else passed++;
  endtask

  task automatic test_oneshot();
    logic [19:0] mask = '0;
    logic [3:0] m2 = '0;
    write(2'd1, 5, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      mask[k-1] = sig[1];
    end
    total++;
    if (mask !== 20'h00020)
      $display("FAIL oneshot_pulse: mask=%h required 00020", mask);
    else passed++;
    total++;
    if (flg[1] !== 1'b0)
      $display("FAIL oneshot_flg: flg1=%b required 0", flg[1]);
    else passed++;
    write(2'd1, 1, 1'b0);
    total++;
    if (flg[1] !== 1'b1)
      $display("FAIL rearm_flg: flg1=%b required 1", flg[1]);
    else passed++;
    for (int k = 1; k <= 4; k++) begin
      tick();
      m2[k-1] = sig[1];
    end
    total++;
    if (m2 !== 4'b1010)
      $display("FAIL rearm_pulse: mask=%b required 1010", m2);
    else passed++;
  endtask

  task automatic test_enable_toggle();
    logic [19:0] mask = '0;
    write(2'd0, 4, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      en = {2'b11, (k % 2 == 1)};
      tick();
      mask[k-1] = sig[0];
    end
    en = '1;
    total++;
    if (mask !== 20'h40100)
      $display("FAIL en_toggle: mask=%h required 40100", mask);
    else passed++;
  endtask

  task automatic test_write_on_tc();
    logic [2:0] mask = '0;
    write(2'd0, 2, 1'b0);
    tick();
    tick();
    write(2'd0, 2, 1'b0);
    total++;
    if (sig[0] !== 1'b0 || cfg_ready !== 1'b0)
      $display("FAIL write_wins: sig0=%b rdy=%b required 0 0", sig[0], cfg_ready);
    else passed++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      mask[k-1] = sig[0];
      if (k == 1) begin
        total++;
        if (cfg_ready !== 1'b1)
          $display("FAIL ready_back: cfg_ready=%b required 1", cfg_ready);
        else passed++;
      end
    end
    total++;
    if (mask !== 3'b100)
      $display("FAIL after_tc_write: mask=%b required 100", mask);
    else passed++;
  endtask

  task automatic test_bad_channel();
    logic any = 1'b0;
    write(2'd1, 0, 1'b1);
    tick();
    total++;
    if (sig[1] !== 1'b1 || flg[1] !== 1'b0)
      $display("FAIL p0_oneshot: sig1=%b flg1=%b required 1 0", sig[1], flg[1]);
    else passed++;
    write(2'd3, 5, 1'b0);
    total++;
    if (cfg_err !== 1'b1)
      $display("FAIL cfg_err_pulse: cfg_err=%b required 1", cfg_err);
    else passed++;
    tick();
    total++;
    if (cfg_err !== 1'b0)
      $display("FAIL cfg_err_clear: cfg_err=%b required 0", cfg_err);
    else passed++;
    for (int k = 0; k < 8; k++) begin
      tick();
      any |= sig[1] | flg[1];
    end
    total++;
    if (any !== 1'b0)
      $display("FAIL bad_ch_no_change: sig1|flg1=%b required 0", any);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int first = 0;
    rst = 1'b1;
    tick();
    total++;
    if ({sig, err, flg, cfg_ready, cfg_err} !== {3'b000, 3'b000, 3'b111, 1'b0, 1'b0})
      $display("FAIL mid_reset: sig=%b err=%b flg=%b rdy=%b cerr=%b required 000 000 111 0 0",
               sig, err, flg, cfg_ready, cfg_err);
    else passed++;
    rst = 1'b0;
    for (int k = 1; k <= 800 && first == 0; k++) begin
      tick();
      if (sig[0]) first = k;
    end
    total++;
    if (first !== 751)
      $display("FAIL reset_restart: edge=%0d required 751", first);
    else passed++;
  endtask

  task automatic test_random();
    logic [2:0] err_or = '0;
    logic cerr_or = 1'b0;
    for (int k = 0; k < 400; k++) begin
      en          = 3'($urandom);
      cfg_valid   = ($urandom % 4) == 0;
      cfg_ch      = 2'($urandom % 3);
      cfg_period  = CB'($urandom_range(0, 20));
      cfg_oneshot = 1'($urandom);
      tick();
      err_or  |= err;
      cerr_or |= cfg_err;
    end
    cfg_valid = 1'b0;
    total++;
    if (err_or !== 3'b000 || cerr_or !== 1'b0)
      $display("FAIL random_err: err_or=%b cfg_err_or=%b required 000 0", err_or, cerr_or);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_periodic_write();
    test_oneshot();
    test_enable_toggle();
    test_write_on_tc();
    test_bad_channel();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/delay_bank.md
# delay_bank

Parametrised multi-channel successor of the single fixed-period delay counter. Each of `NCH` channels counts enabled cycles against its own runtime-programmable period. Each channel emits a one-cycle `sig` pulse at terminal count and runs in periodic or one-shot mode. A valid/ready configuration port reprograms one channel per write; per-channel `err` and `flg` outputs keep the invariant-monitor role of the earlier block so properties can be written per channel.

## Interface
- `NCH`, 4: number of independent channels (1..16).
- `CBITS`, 10: counter and period width.
- `N_DEFAULT`, 750: period loaded into every channel at reset; must fit in `CBITS`.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  NCH  per-channel count enable.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  config write can be accepted.
- `cfg_ch`  in  max(1,$clog2(NCH))  target channel.
- `cfg_period`  in  CBITS  new period P.
- `cfg_oneshot`  in  1  1 = one-shot, 0 = periodic.
- `cfg_err`  out  1  one-cycle pulse: accepted write had `cfg_ch >= NCH`.
- `sig`  out  NCH  terminal-count pulse.
- `err`  out  NCH  invariant violation, counter exceeds period.
- `flg`  out  NCH  channel armed and counter within period.

## Operation
- Per-channel state: `cnt[CBITS]`, `period[CBITS]`, `oneshot`, and FSM state `RUN` or `DONE`.
- Reset, held one or more cycles:
  - `cnt`=0, `period`=`N_DEFAULT`, `oneshot`=0, state `RUN`.
  - `sig`=0, `err`=0, `flg`=all 1, `cfg_ready`=0, `cfg_err`=0.
- `RUN` with `en[i]`=1:
  - If `cnt==period`: `cnt`<=0 and `sig[i]`<=1. If `oneshot`, next state is `DONE`.
  - Otherwise: `cnt`<=`cnt`+1 and `sig[i]`<=0.
- `RUN` with `en[i]`=0: `cnt` and state hold; `sig[i]`<=0.
- `DONE`: `cnt` held at 0, `sig[i]`=0, `flg[i]`=0. The channel ignores `en` until a config write or reset.
- Period semantics: P gives one pulse every P+1 enabled cycles. P=0 gives `sig` high on every enabled cycle in periodic mode.
- Config handshake:
  - A write is accepted on a cycle with `cfg_valid && cfg_ready`.
  - On acceptance, the target channel loads `period`, `oneshot`, `cnt`<=0, state `RUN`, and its `sig`<=0.
  - `cfg_ready` deasserts for exactly the cycle after each accepted write. Back-to-back writes therefore complete at one per two cycles.
  - `cfg_ch >= NCH`: the write is accepted, no channel changes, and `cfg_err` pulses the next cycle.
- Simultaneous events:
  - Config write and terminal count on the same channel in the same cycle: the write wins and no `sig` is produced.
  - Writes never affect other channels.
  - `rst` overrides everything.
- `err[i]` <= (`cnt > period`), registered. Correct RTL never asserts it, because a reload always clears `cnt`.
- `flg[i]` <= (state==`RUN` && `cnt <= period`), registered from next-state values.
- Arithmetic: `cnt` never wraps, because it clears at `period` ≤ 2^CBITS−1. Comparisons are unsigned, at `CBITS` width.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `sig` rises the cycle after the edge at which `cnt==period` with `en` high.
- From reset release with `en` held high and P=750, the first `sig` appears 751 cycles after the first enabled edge. Subsequent pulses follow every 751 cycles.
- Config write accepted at edge t: the channel's first enabled count is at edge t+1, and the first `sig` occurs P+1 enabled edges later.
- `cfg_ready` first rises the cycle after `rst` falls.
- Reset mid-count: the counter is cleared at that edge; there are no pending pulses.

## Structure
- Package `delay_pkg` holds:
  - `typedef enum logic {RUN, DONE} chan_state_t`.
  - Default `CBITS` and `N_DEFAULT` constants.
  - A `chan_cfg_t` struct {period, oneshot}.
- Sub-module `delay_chan`: one channel's counter, FSM and sig/err/flg registers. Its inputs are `clk`, `rst`, `en`, `load`, and the load payload.
- `delay_bank` contains the config handshake, channel decode, `cfg_err`, and a generate loop of `NCH` × `delay_chan`.

## Test plan
- Reset release, `en`=all 1, no writes, P=750: each `sig` pulses at cycles 751, 1502, …; `err` always 0; `flg` is 0 only in `DONE`.
- Write ch2 with P=3, periodic: ch2 `sig` every 4 cycles; other channels undisturbed.
- Write ch1 with P=5, one-shot: a single `sig` after 6 enabled cycles, then `flg[1]`=0 and `sig[1]` stays 0. A rewrite re-arms the channel.
- `en[0]` toggles 1/0 each cycle with P=4: `sig[0]` every 10 cycles; `cnt` holds on disabled cycles.
- Write to ch0 on its terminal-count cycle: no pulse. `cfg_ready` low the next cycle. Write with `cfg_ch`=NCH (non-power-of-two build, NCH=3): `cfg_err` pulses and no channel changes.
- Assert `rst` mid-count: all outputs return to reset values on the next edge. Randomised run: `err` never 1.
